// File: rtl/ras_ckpt.sv
// Checkpointable return address stack: circular buffer of return PCs with
// push, pop, return-and-link replace, and pointer/occupancy restore.
module ras_ckpt #(
   parameter int                       RAS_ENTRIES     = 16,
   parameter int                       PC_WIDTH        = 38,
   parameter logic [PC_WIDTH-1:0]      INIT_PC         = '0,
   localparam int                      LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES)
) (
   input  logic                        CLK,
   input  logic                        nRST,
   input  logic                        push_valid,
   input  logic [PC_WIDTH-1:0]         push_pc,
   input  logic                        pop_valid,
   input  logic                        restore_valid,
   input  logic [LOG_RAS_ENTRIES-1:0]  restore_idx,
   input  logic [LOG_RAS_ENTRIES:0]    restore_count,
   output logic [PC_WIDTH-1:0]         tos_pc,
   output logic                        tos_valid,
   output logic [LOG_RAS_ENTRIES-1:0]  ras_idx,
   output logic [LOG_RAS_ENTRIES:0]    ras_count
);

   localparam logic [LOG_RAS_ENTRIES-1:0] PTR_ONE    = LOG_RAS_ENTRIES'(1);
   localparam logic [LOG_RAS_ENTRIES:0]   CNT_ONE    = (LOG_RAS_ENTRIES+1)'(1);
   localparam logic [LOG_RAS_ENTRIES:0]   CNT_ZERO   = (LOG_RAS_ENTRIES+1)'(0);
   localparam logic [LOG_RAS_ENTRIES:0]   FULL_COUNT = (LOG_RAS_ENTRIES+1)'(RAS_ENTRIES);

   logic [PC_WIDTH-1:0]        mem_r [RAS_ENTRIES];
   logic [LOG_RAS_ENTRIES-1:0] ptr_r;
   logic [LOG_RAS_ENTRIES:0]   count_r;

   logic [LOG_RAS_ENTRIES-1:0] ptr_s;
   logic [LOG_RAS_ENTRIES:0]   count_s;
   logic                       wr_en_s;
   logic [LOG_RAS_ENTRIES-1:0] wr_idx_s;

   // Next pointer, occupancy and write port; restore outranks push/pop.
   always_comb begin
      ptr_s    = ptr_r;
      count_s  = count_r;
      wr_en_s  = 1'b0;
      wr_idx_s = ptr_r;
      if (restore_valid) begin
         ptr_s   = restore_idx;
         count_s = restore_count;
      end else if (push_valid && !pop_valid) begin
         // When full the new entry silently overwrites the oldest one.
         ptr_s    = ptr_r + PTR_ONE;
         wr_en_s  = 1'b1;
         wr_idx_s = ptr_r + PTR_ONE;
         if (count_r == FULL_COUNT) begin
            count_s = count_r;
         end else begin
            count_s = count_r + CNT_ONE;
         end
      end else if (push_valid && pop_valid) begin
         wr_en_s  = 1'b1;
         wr_idx_s = ptr_r;
         if (count_r == CNT_ZERO) begin
            count_s = CNT_ONE;
         end else begin
            count_s = count_r;
         end
      end else if (pop_valid) begin
         // Underflow leaves the stack untouched.
         if (count_r != CNT_ZERO) begin
            ptr_s   = ptr_r - PTR_ONE;
            count_s = count_r - CNT_ONE;
         end else begin
            ptr_s   = ptr_r;
            count_s = count_r;
         end
      end else begin
         ptr_s   = ptr_r;
         count_s = count_r;
      end
   end

   // State registers with synchronous active-low reset clearing every entry.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         ptr_r   <= '0;
         count_r <= '0;
         for (int i = 0; i < RAS_ENTRIES; i++) begin
            mem_r[i] <= INIT_PC;
         end
      end else begin
         ptr_r   <= ptr_s;
         count_r <= count_s;
         if (wr_en_s) begin
            mem_r[wr_idx_s] <= push_pc;
         end
      end
   end

   // Outputs decode registered state only.
   always_comb begin
      ras_idx   = ptr_r;
      ras_count = count_r;
      tos_valid = (count_r != CNT_ZERO);
      if (count_r != CNT_ZERO) begin
         tos_pc = mem_r[ptr_r];
      end else begin
         tos_pc = INIT_PC;
      end
   end

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed and random checks of ras_ckpt against an array-based stack model.
module tb_ras_ckpt;

   localparam int          DEPTH = 16;
   localparam int          PCW   = 38;
   localparam logic [37:0] INIT  = 38'h2A_5A5A_0F0F;

   logic            CLK = 1'b0;
   logic            nRST = 1'b0;
   logic            push_valid = 1'b0;
   logic [PCW-1:0]  push_pc = '0;
   logic            pop_valid = 1'b0;
   logic            restore_valid = 1'b0;
   logic [3:0]      restore_idx = 4'd0;
   logic [4:0]      restore_count = 5'd0;
   logic [PCW-1:0]  tos_pc;
   logic            tos_valid;
   logic [3:0]      ras_idx;
   logic [4:0]      ras_count;

   int vectors = 0;
   int miscompares = 0;

   logic [PCW-1:0] m_mem [DEPTH];
   int             m_ptr;
   int             m_cnt;

   ras_ckpt #(.RAS_ENTRIES(DEPTH), .PC_WIDTH(PCW), .INIT_PC(INIT)) dut (
      .CLK(CLK), .nRST(nRST),
      .push_valid(push_valid), .push_pc(push_pc), .pop_valid(pop_valid),
      .restore_valid(restore_valid), .restore_idx(restore_idx),
      .restore_count(restore_count),
      .tos_pc(tos_pc), .tos_valid(tos_valid),
      .ras_idx(ras_idx), .ras_count(ras_count)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit rst_n, input bit push, input logic [PCW-1:0] pc,
                             input bit pop, input bit rv, input int ri, input int rc);
      if (!rst_n) begin
         m_ptr = 0;
         m_cnt = 0;
         for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT;
      end else if (rv) begin
         m_ptr = ri;
         m_cnt = rc;
      end else if (push && !pop) begin
         m_ptr = (m_ptr + 1) % DEPTH;
         m_mem[m_ptr] = pc;
         if (m_cnt < DEPTH) m_cnt++;
      end else if (push && pop) begin
         m_mem[m_ptr] = pc;
         if (m_cnt == 0) m_cnt = 1;
      end else if (pop && m_cnt > 0) begin
         m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
         m_cnt--;
      end
   endtask

   task automatic check_model(input string tag);
      logic [PCW-1:0] exp_tos;
      exp_tos = (m_cnt == 0) ? INIT : m_mem[m_ptr];
      check_eq({tag, ".tos_pc"}, 64'(tos_pc), 64'(exp_tos));
      check_eq({tag, ".tos_valid"}, 64'(tos_valid), 64'(m_cnt != 0));
      check_eq({tag, ".ras_idx"}, 64'(ras_idx), 64'(m_ptr));
      check_eq({tag, ".ras_count"}, 64'(ras_count), 64'(m_cnt));
   endtask

   task automatic expect_out(input string tag, input logic [PCW-1:0] e_tos, input bit e_valid,
                             input int e_idx, input int e_cnt);
      check_eq({tag, ".tos_pc"}, 64'(tos_pc), 64'(e_tos));
      check_eq({tag, ".tos_valid"}, 64'(tos_valid), 64'(e_valid));
      check_eq({tag, ".ras_idx"}, 64'(ras_idx), 64'(e_idx));
      check_eq({tag, ".ras_count"}, 64'(ras_count), 64'(e_cnt));
   endtask

   task automatic step(input string tag, input bit rst_n, input bit push,
                       input logic [PCW-1:0] pc, input bit pop, input bit rv,
                       input int ri, input int rc);
      nRST          = rst_n;
      push_valid    = push;
      push_pc       = pc;
      pop_valid     = pop;
      restore_valid = rv;
      restore_idx   = 4'(ri);
      restore_count = 5'(rc);
      @(posedge CLK);
      model_step(rst_n, push, pc, pop, rv, ri, rc);
      #1;
      nRST = 1'b1; push_valid = 1'b0; pop_valid = 1'b0; restore_valid = 1'b0;
      check_model(tag);
   endtask

   task automatic do_push(input logic [PCW-1:0] pc);
      step("push", 1'b1, 1'b1, pc, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic do_pop();
      step("pop", 1'b1, 1'b0, '0, 1'b1, 1'b0, 0, 0);
   endtask

   task automatic do_reset();
      step("reset", 1'b0, 1'b0, '0, 1'b0, 1'b0, 0, 0);
   endtask

   initial begin
      int r;
      logic [PCW-1:0] rpc;

      do_reset();
      do_reset();
      expect_out("reset_state", INIT, 1'b0, 0, 0);

      do_push(38'h100);
      do_push(38'h200);
      do_push(38'h300);
      expect_out("push3", 38'h300, 1'b1, 3, 3);
      do_pop();
      expect_out("pop1", 38'h200, 1'b1, 2, 2);

      // Overflow wrap: 17 pushes at depth 16 starting from an empty stack.
      do_reset();
      for (int i = 1; i <= 17; i++) do_push(PCW'(i));
      expect_out("wrap17", 38'd17, 1'b1, 1, 16);
      for (int i = 0; i < 15; i++) do_pop();
      expect_out("pop15", 38'd2, 1'b1, 2, 1);
      do_pop();
      expect_out("pop_to_empty", INIT, 1'b0, 1, 0);

      do_reset();
      do_pop();
      expect_out("underflow", INIT, 1'b0, 0, 0);

      do_push(38'hA);
      do_push(38'hB);
      step("ral", 1'b1, 1'b1, 38'hC, 1'b1, 1'b0, 0, 0);
      expect_out("ral_replace", 38'hC, 1'b1, 2, 2);
      do_reset();
      step("ral_empty", 1'b1, 1'b1, 38'hD, 1'b1, 1'b0, 0, 0);
      expect_out("ral_empty", 38'hD, 1'b1, 0, 1);

      // Checkpoint at (2,2), disturb, then restore alongside a push that must be dropped.
      do_reset();
      do_push(38'hA);
      do_push(38'hB);
      do_push(38'hE);
      do_pop();
      do_pop();
      step("restore_push", 1'b1, 1'b1, 38'hF, 1'b0, 1'b1, 2, 2);
      expect_out("restore", 38'hB, 1'b1, 2, 2);
      step("restore3", 1'b1, 1'b0, '0, 1'b0, 1'b1, 3, 3);
      expect_out("restore3", 38'hE, 1'b1, 3, 3);

      // Reset beats a simultaneous push; every entry must read back INIT.
      for (int i = 0; i < 5; i++) do_push(PCW'(32'h1000 + i));
      step("rst_push", 1'b0, 1'b1, 38'h77, 1'b0, 1'b0, 0, 0);
      expect_out("rst_over_push", INIT, 1'b0, 0, 0);
      for (int k = 0; k < DEPTH; k++) begin
         step("scan", 1'b1, 1'b0, '0, 1'b0, 1'b1, k, DEPTH);
         expect_out("scan_init", INIT, 1'b1, k, DEPTH);
      end

      for (int n = 0; n < 3000; n++) begin
         r   = int'($urandom_range(255, 0));
         rpc = {6'($urandom), $urandom};
         if (r == 0)
            step("rand", 1'b0, 1'($urandom), rpc, 1'($urandom), 1'($urandom), 0, 0);
         else if (r < 16)
            step("rand", 1'b1, 1'($urandom), rpc, 1'($urandom), 1'b1,
                 int'($urandom_range(15, 0)), int'($urandom_range(16, 0)));
         else
            step("rand", 1'b1, 1'($urandom), rpc, 1'($urandom), 1'b0, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
